// File: rtl/aes_pkg.sv
// Shared AES byte type and the FIPS-197 forward/inverse S-box constant ROMs.
package aes_pkg;

  typedef logic [7:0] aes_byte;

  localparam aes_byte SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sub_bytes_pipe.sv
// Parallel SubBytes/InvSubBytes on LANES bytes, followed by STAGES elastic
// valid/ready pipeline registers that collapse bubbles.
module aes_sub_bytes_pipe #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic                               inv_i,
  input  aes_pkg::aes_byte [LANES-1:0]       data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output aes_pkg::aes_byte [LANES-1:0]       data_o
);

  typedef aes_pkg::aes_byte [LANES-1:0] word_t;

  word_t             sub_data;
  word_t             stage_data [1:STAGES];
  word_t             src_data   [1:STAGES];
  logic [STAGES:1]   vld;
  logic [STAGES:1]   load;
  logic [STAGES:1]   src_vld;

  always_comb begin
    sub_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sub_data[k] = inv_i ? aes_pkg::INV_SBOX[data_i[k]] : aes_pkg::SBOX[data_i[k]];
    end
  end

  // Unrolled form of load[s] = !vld[s] || load[s+1]: a stage can move when
  // the sink is ready or any stage from here to the output is empty.
  for (genvar s = 1; s <= STAGES; s++) begin : g_load
    assign load[s] = ready_i || !(&vld[STAGES:s]);
  end

  always_comb begin
    src_vld     = '0;
    src_data    = '{default: '0};
    src_vld[1]  = valid_i;
    src_data[1] = sub_data;
    for (int unsigned s = 2; s <= STAGES; s++) begin
      src_vld[s]  = vld[s-1];
      src_data[s] = stage_data[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= '0;
      for (int unsigned s = 1; s <= STAGES; s++) begin
        stage_data[s] <= '0;
      end
    end else if (flush_i) begin
      vld <= '0;
    end else begin
      for (int unsigned s = 1; s <= STAGES; s++) begin
        if (load[s]) begin
          vld[s] <= src_vld[s];
          if (src_vld[s]) begin
            stage_data[s] <= src_data[s];
          end
        end
      end
    end
  end

  assign ready_o = load[1] && !flush_i;
  assign valid_o = vld[STAGES];
  assign data_o  = stage_data[STAGES];

endmodule

// File: doc/aes_sub_bytes_pipe.md
# aes_sub_bytes_pipe

Parametrised, pipelined SubBytes/InvSubBytes unit. Applies the AES S-box (FIPS-197) or its inverse to `LANES` bytes in parallel and registers the result through `STAGES` elastic pipeline stages with a valid/ready handshake. It sits between the round-state datapath and the round-key mixer, and serves both the encrypt and decrypt rounds and key expansion (`LANES`=4).

## Interface
- `LANES`, default 16: bytes substituted per transaction; legal 1..16.
- `STAGES`, default 2: pipeline register stages; legal 1..4.
- `clk_i`  in  1  clock, all state rises on posedge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- `flush_i`  in  1  synchronous clear of all in-flight entries.
- `valid_i`  in  1  input transaction present.
- `ready_o`  out  1  unit accepts a transaction this cycle.
- `inv_i`  in  1  0 = forward S-box, 1 = inverse S-box; sampled with `valid_i`.
- `data_i`  in  `LANES` x `aes_pkg::aes_byte`  input bytes.
- `valid_o`  out  1  output transaction present.
- `ready_i`  in  1  downstream accepts output.
- `data_o`  out  `LANES` x `aes_pkg::aes_byte`  substituted bytes.

## Operation
- Accept: transfer in when `valid_i && ready_o`. Release: transfer out when `valid_o && ready_i`.
- Substitution is combinational on the input side. Each lane k yields SBOX[data_i[k]] when `inv_i`=0 and INV_SBOX[data_i[k]] when `inv_i`=1. The result is written into stage 1. `inv_i` is not carried down the pipe.
- Both tables are 256-entry constant ROMs per FIPS-197. INV_SBOX[SBOX[x]] = x for all x.
- Lanes are independent. Lane k in maps to lane k out, with no reordering across lanes or transactions.
- Stage s (1..`STAGES`) holds `vld[s]` and a data word. Stage `STAGES` drives `valid_o`/`data_o`.
- Elastic advance: stage s loads from stage s-1 (or from the input for s=1) when `!vld[s] || adv[s+1]`. Here adv[`STAGES`+1] = `ready_i`, and adv[s] = load condition of stage s.
- This collapses bubbles. An empty stage fills even while the output is stalled.
- `ready_o` = load condition of stage 1, combinational from `vld[*]` and `ready_i`. It never depends on `valid_i`.
- A stage that is not loading holds its data and valid unchanged. Output data stays stable while `valid_o && !ready_i`.
- `flush_i`=1 clears all `vld[s]` at the next edge. Any input presented that cycle is dropped, and `ready_o` is forced 0 during `flush_i`. Data registers are not cleared.
- Reset (`rst_ni`=0, asynchronous): all `vld[s]`=0 and all data registers = 0. Thus `valid_o`=0, `data_o`=0, and `ready_o`=1 (subject to `flush_i`) while in and after reset.
- Data registers load only on a stage load. Invalid stages may hold stale data; `data_o` is defined only while `valid_o`=1.

## Timing
- Latency: accept at edge N gives `valid_o`=1 after edge N+`STAGES-1`. With `STAGES`=1 it is valid in the cycle following the accept edge. In general the transfer occurs `STAGES` cycles after accept when no backpressure.
- Throughput: one transaction per cycle with `ready_i` held high.
- Full pipeline (all `vld`=1) with `ready_i`=0 gives `ready_o`=0. It holds `STAGES` entries, with no loss and no overwrite.
- Simultaneous accept and release when full and `ready_i`=1: both occur in the same cycle and occupancy is unchanged.
- No combinational path from `valid_i` or `data_i` to any output. `ready_i` to `ready_o` is combinational, with depth ≤ `STAGES` AND/OR levels.
- Reset mid-operation drops all entries immediately; no partial outputs.

## Test plan
- Forward, `LANES`=16, `STAGES`=2, `ready_i`=1: bytes {00,53,FF,01,...}. Outputs {63,ED,16,7C,...} with `valid_o` 2 cycles after accept. Sweep all 256 values.
- Inverse: {63,ED,16,00} with `inv_i`=1 gives {00,53,FF,52}. Forward then inverse of all 256 values returns the original.
- Back-to-back mode mixing: alternate `inv_i` each cycle for 8 transactions. Each output matches its own mode, in order, at 1/cycle.
- Backpressure: `ready_i`=0 for 5 cycles while driving valid. `ready_o` falls after `STAGES` accepts and `data_o` is stable. After `ready_i`=1 all entries emerge in order, with no loss or duplication.
- Bubble collapse: one transaction, stall the output, inject a second one. Both stages fill. Random `valid_i`/`ready_i` at 50% against a scoreboard model.
- Flush and async reset: flush with 2 in-flight entries gives `valid_o`=0 next cycle and input dropped. Asserting `rst_ni`=0 mid-burst, off a clock edge, gives `valid_o`=0 and `data_o`=00 immediately, and `ready_o`=1.
